design_1_wrapper_sim_wrapper_top: RTL and testbench
===================================================

DESIGN_1_WRAPPER_SIM_WRAPPER_TOP -- requirements
Module: design_1_wrapper_sim_wrapper

Interface
REQ-001 Parameters: NUM_SOCKETS=2, number of socket models; SOCKET_RUN_CYCLES=64, socket busy time; MMIO_REG_SPACE=9, MMIO select bit.
REQ-002 clkwiz_clk_in1  in  1  sole clock; all logic on its rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 user_clk  out  1  direct buffer of clkwiz_clk_in1.
REQ-005 sys_clk_clk_p/n, clkwiz_reset, clkwiz_clk_out1_ce, clkwiz_clk_out1_clr_n  in  1 each  unused; no effect.
REQ-006 CH0_DDR4_* (act_n 1, adr 17, ba 2, bg 2, ck_c/ck_t/cke/cs_n/odt/reset_n 1, dm_n 8, dqs_c/dqs_t 8, dq 64)  out/inout  DDR pins; outputs drive 0, inouts drive high-Z.
REQ-007 mem_len  in  32  generator transfer length in 64-byte beats; ddr_addr, ram_addr  in  64  base addresses, latched only.
REQ-008 start_write, start_read  in  1  one-cycle start pulses; done_write, done_read  out  1  completion flags; dump_mem  in  1  no effect.
REQ-009 s_axi_control AXI4-Lite slave: araddr/awaddr in 32, arvalid/awvalid/wvalid/rready/bready in 1, wdata in 32, wstrb in 4 (ignored), arready/awready/wready/rvalid/bvalid out 1, rdata out 32, rresp/bresp out 2 (always 0).

Function
REQ-010 Write channel: idle -> awready=1; on AW fire latch address -> wready=1; on W fire perform register write -> bvalid=1 until B fire -> idle. One write at a time.
REQ-011 Read channel: idle -> arready=1; on AR fire, next cycle rvalid=1 with rdata held stable until R fire -> idle.
REQ-012 Control registers (byte addresses):
- 0x00 CSR: write 1 = socket write of WDATA to target OFFSET; read returns 0 and starts a socket read of OFFSET.
- 0x10 OFFSET_LO, 0x14 OFFSET_HI: R/W.
- 0x18 WR_IDLE: RO, 1 while a socket write is pending, else 0.
- 0x1c RDATA: RO, last socket read result. 0x20 WDATA: R/W.
- 0x24 RCNT: any write clears to 0; set to 1 when a socket read completes. 0x28 WCNT: RO, count of completed socket writes.
- 0x38 QUEUE_ENQ, 0x3c QUEUE_DEQ, 0x40 STATUS: see REQ-016 to REQ-018. Other addresses read 0; writes to them are ignored.
REQ-013 Target decode: socket index = OFFSET_LO[31:24]; word index = OFFSET_LO[23:6]; bit MMIO_REG_SPACE of word index must be 1, else access ignored (read returns 0); register = low 9 bits of word index; socket index >= NUM_SOCKETS is ignored; OFFSET_HI is not decoded.
REQ-014 Socket writes and reads complete 4 cycles after issue; WR_IDLE is 1 during those cycles; a CSR write while busy is dropped.
REQ-015 Socket MMIO registers:
- 64 CSR: write bit0=1 starts the socket; read bit0=busy, bit1=done.
- 65/66 EXT_MEM_OFFSET lo/hi: R/W.
- 256 RESET: write 1 clears busy and done.
REQ-016 Started socket is busy for SOCKET_RUN_CYCLES, then done=1 and STATUS[i]=1; done holds until the socket is reset or restarted.
REQ-017 Queue: FIFO of depth 4 holding OFFSET_LO; write to 0x38 pushes (dropped when full); write to 0x3c drains all entries, one socket write of WDATA per entry, each using the REQ-014 timing.
REQ-018 STATUS read returns done bits [NUM_SOCKETS-1:0]; any write clears all bits.
REQ-019 Generator: start_write pulse -> done_write=0, then done_write=1 after max(mem_len,1)+8 cycles. start_read -> done_read with the same timing. Each done flag holds until the next start of the same kind.

Reset
REQ-020 resetn low asynchronously clears all registers, queue, sockets and the generator. Ready/valid outputs, rdata, done_write and done_read are 0 during reset; user_clk keeps toggling.

Configuration
REQ-021 Macro CYCLE_COUNTER_EN:
- Defined: 32-bit free-running counter, cleared by reset, readable at 0x44.
- Undefined: 0x44 reads 0.

Verification
REQ-022 Reset, then start_write with mem_len=0 -> done_write=1 exactly 9 cycles after the pulse.
REQ-023 OFFSET_LO=(65+512)<<6, WDATA=0x5, CSR write 1, then CSR read -> WR_IDLE reads 1 then 0; RCNT=1; RDATA=0x5.
REQ-024 Enqueue CSR offsets ((64+512)<<6)+(i<<24) for i=0,1; WDATA=1; write 0x3c -> STATUS reads 0x3 after about 64 cycles.
REQ-025 Write socket RESET register with 1 after completion, then write STATUS 0 -> STATUS reads 0; socket CSR read returns 0.
REQ-026 Assert resetn low mid-run -> every output clears immediately and stays clear until reset is released.

Source files
------------

// File: rtl/design_1_wrapper_sim_wrapper_top.sv
// Simulation stand-in for the design_1 platform: AXI4-Lite control block, socket models,
// a small work queue and a traffic generator. Optional feature macro: CYCLE_COUNTER_EN.
module design_1_wrapper_sim_wrapper_top #(
    parameter int NUM_SOCKETS       = 2,
    parameter int SOCKET_RUN_CYCLES = 64,
    parameter int MMIO_REG_SPACE    = 9
) (
    input  logic        clkwiz_clk_in1,
    input  logic        resetn,
    output logic        user_clk,
    input  logic        sys_clk_clk_p,
    input  logic        sys_clk_clk_n,
    input  logic        clkwiz_reset,
    input  logic        clkwiz_clk_out1_ce,
    input  logic        clkwiz_clk_out1_clr_n,
    output logic        CH0_DDR4_act_n,
    output logic [16:0] CH0_DDR4_adr,
    output logic [1:0]  CH0_DDR4_ba,
    output logic [1:0]  CH0_DDR4_bg,
    output logic        CH0_DDR4_ck_c,
    output logic        CH0_DDR4_ck_t,
    output logic        CH0_DDR4_cke,
    output logic        CH0_DDR4_cs_n,
    output logic        CH0_DDR4_odt,
    output logic        CH0_DDR4_reset_n,
    inout  wire  [7:0]  CH0_DDR4_dm_n,
    inout  wire  [7:0]  CH0_DDR4_dqs_c,
    inout  wire  [7:0]  CH0_DDR4_dqs_t,
    inout  wire  [63:0] CH0_DDR4_dq,
    input  logic [31:0] mem_len,
    input  logic [63:0] ddr_addr,
    input  logic [63:0] ram_addr,
    input  logic        start_write,
    input  logic        start_read,
    output logic        done_write,
    output logic        done_read,
    input  logic        dump_mem,
    input  logic [31:0] s_axi_control_araddr,
    input  logic        s_axi_control_arvalid,
    output logic        s_axi_control_arready,
    input  logic [31:0] s_axi_control_awaddr,
    input  logic        s_axi_control_awvalid,
    output logic        s_axi_control_awready,
    input  logic [31:0] s_axi_control_wdata,
    input  logic [3:0]  s_axi_control_wstrb,
    input  logic        s_axi_control_wvalid,
    output logic        s_axi_control_wready,
    output logic [1:0]  s_axi_control_bresp,
    output logic        s_axi_control_bvalid,
    input  logic        s_axi_control_bready,
    output logic [31:0] s_axi_control_rdata,
    output logic [1:0]  s_axi_control_rresp,
    output logic        s_axi_control_rvalid,
    input  logic        s_axi_control_rready
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    localparam int RUN_W     = (SOCKET_RUN_CYCLES > 1) ? $clog2(SOCKET_RUN_CYCLES) : 1;
    localparam int SPACE_BIT = 6 + MMIO_REG_SPACE;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic ready_en, aw_fire, w_fire, ar_fire;
    logic [31:0] aw_addr, offset_lo, offset_hi, wdata_reg, sock_rdata, rcnt, wcnt;
    logic [31:0] rd_mux, cycle_rd, sock_rd_val;
    logic wr_pending, rd_pending, wr_issue, rd_issue, q_issue, wr_complete, rd_complete;
    logic [1:0] wr_cnt, rd_cnt;
    logic [31:0] wr_target, wr_value, rd_target;
    logic [31:0] q_mem [4];
    logic [1:0] q_head, q_tail;
    logic [2:0] q_count;
    logic q_push, draining;
    logic [NUM_SOCKETS-1:0] sock_busy, sock_done, status;
    logic [RUN_W-1:0] sock_cnt [NUM_SOCKETS];
    logic [31:0] ext_lo [NUM_SOCKETS];
    logic [31:0] ext_hi [NUM_SOCKETS];
    logic [32:0] gen_len, gw_cnt, gr_cnt;
    logic gw_run, gr_run;
    logic [63:0] ddr_addr_q, ram_addr_q;
    logic unused_inputs;

    function automatic logic tgt_hit(input logic [31:0] t, input int i);
        return t[SPACE_BIT] && (t[31:24] == 8'(i));
    endfunction

    assign user_clk         = clkwiz_clk_in1;
    assign CH0_DDR4_act_n   = 1'b0;
    assign CH0_DDR4_adr     = '0;
    assign CH0_DDR4_ba      = '0;
    assign CH0_DDR4_bg      = '0;
    assign CH0_DDR4_ck_c    = 1'b0;
    assign CH0_DDR4_ck_t    = 1'b0;
    assign CH0_DDR4_cke     = 1'b0;
    assign CH0_DDR4_cs_n    = 1'b0;
    assign CH0_DDR4_odt     = 1'b0;
    assign CH0_DDR4_reset_n = 1'b0;
    assign CH0_DDR4_dm_n    = 'z;
    assign CH0_DDR4_dqs_c   = 'z;
    assign CH0_DDR4_dqs_t   = 'z;
    assign CH0_DDR4_dq      = 'z;
    assign s_axi_control_bresp = 2'b00;
    assign s_axi_control_rresp = 2'b00;
    assign unused_inputs = ^{sys_clk_clk_p, sys_clk_clk_n, clkwiz_reset, clkwiz_clk_out1_ce,
                             clkwiz_clk_out1_clr_n, dump_mem, s_axi_control_wstrb,
                             ddr_addr_q, ram_addr_q, wr_target, rd_target};

    assign aw_fire     = s_axi_control_awvalid && s_axi_control_awready;
    assign w_fire      = s_axi_control_wvalid && s_axi_control_wready;
    assign ar_fire     = s_axi_control_arvalid && s_axi_control_arready;
    assign q_issue     = draining && !wr_pending && (q_count != 3'd0);
    assign wr_issue    = q_issue || (w_fire && aw_addr == 32'h00 && s_axi_control_wdata[0]
                                     && !wr_pending && !draining);
    assign rd_issue    = ar_fire && s_axi_control_araddr == 32'h00 && !rd_pending;
    assign wr_complete = wr_pending && (wr_cnt == 2'd3);
    assign rd_complete = rd_pending && (rd_cnt == 2'd3);
    assign q_tail      = q_head + q_count[1:0];
    assign q_push      = w_fire && aw_addr == 32'h38 && (q_count != 3'd4);
    assign gen_len     = {1'b0, (mem_len == 32'd0) ? 32'd1 : mem_len} + 33'd7;

    always_ff @(posedge clkwiz_clk_in1 or negedge resetn) begin
        if (!resetn) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            ready_en <= 1'b0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            ready_en <= 1'b1;
        end
    end

    // ready_en keeps every handshake output low until the first edge after reset
    always_comb begin
        w_next = w_state;
        r_next = r_state;
        s_axi_control_awready = 1'b0;
        s_axi_control_wready  = 1'b0;
        s_axi_control_bvalid  = 1'b0;
        s_axi_control_arready = 1'b0;
        s_axi_control_rvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_control_awready = ready_en;
                if (s_axi_control_awvalid && ready_en) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi_control_wready = 1'b1;
                if (s_axi_control_wvalid) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_control_bvalid = 1'b1;
                if (s_axi_control_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE: begin
                s_axi_control_arready = ready_en;
                if (s_axi_control_arvalid && ready_en) r_next = R_DATA;
            end
            R_DATA: begin
                s_axi_control_rvalid = 1'b1;
                if (s_axi_control_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        case (s_axi_control_araddr)
            32'h10:  rd_mux = offset_lo;
            32'h14:  rd_mux = offset_hi;
            32'h18:  rd_mux = {31'd0, wr_pending};
            32'h1c:  rd_mux = sock_rdata;
            32'h20:  rd_mux = wdata_reg;
            32'h24:  rd_mux = rcnt;
            32'h28:  rd_mux = wcnt;
            32'h40:  rd_mux = 32'(status);
            32'h44:  rd_mux = cycle_rd;
            default: rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        sock_rd_val = 32'd0;
        for (int i = 0; i < NUM_SOCKETS; i++) begin
            if (tgt_hit(rd_target, i)) begin
                case (rd_target[14:6])
                    9'd64:   sock_rd_val = {30'd0, sock_done[i], sock_busy[i]};
                    9'd65:   sock_rd_val = ext_lo[i];
                    9'd66:   sock_rd_val = ext_hi[i];
                    default: sock_rd_val = 32'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clkwiz_clk_in1 or negedge resetn) begin
        if (!resetn) begin
            aw_addr             <= '0;
            offset_lo           <= '0;
            offset_hi           <= '0;
            wdata_reg           <= '0;
            sock_rdata          <= '0;
            rcnt                <= '0;
            wcnt                <= '0;
            s_axi_control_rdata <= '0;
        end else begin
            if (aw_fire) aw_addr <= s_axi_control_awaddr;
            if (ar_fire) s_axi_control_rdata <= rd_mux;
            if (w_fire) begin
                case (aw_addr)
                    32'h10:  offset_lo <= s_axi_control_wdata;
                    32'h14:  offset_hi <= s_axi_control_wdata;
                    32'h20:  wdata_reg <= s_axi_control_wdata;
                    32'h24:  rcnt      <= 32'd0;
                    default: ;
                endcase
            end
            if (rd_complete) begin
                sock_rdata <= sock_rd_val;
                rcnt       <= 32'd1;
            end
            if (wr_complete) wcnt <= wcnt + 32'd1;
        end
    end

    // Socket access engines: each transfer completes on the fourth edge after issue
    always_ff @(posedge clkwiz_clk_in1 or negedge resetn) begin
        if (!resetn) begin
            wr_pending <= 1'b0;
            wr_cnt     <= '0;
            wr_target  <= '0;
            wr_value   <= '0;
            rd_pending <= 1'b0;
            rd_cnt     <= '0;
            rd_target  <= '0;
        end else begin
            if (wr_issue) begin
                wr_pending <= 1'b1;
                wr_cnt     <= 2'd0;
                wr_target  <= q_issue ? q_mem[q_head] : offset_lo;
                wr_value   <= wdata_reg;
            end else if (wr_pending) begin
                if (wr_cnt == 2'd3) wr_pending <= 1'b0;
                else wr_cnt <= wr_cnt + 2'd1;
            end
            if (rd_issue) begin
                rd_pending <= 1'b1;
                rd_cnt     <= 2'd0;
                rd_target  <= offset_lo;
            end else if (rd_pending) begin
                if (rd_cnt == 2'd3) rd_pending <= 1'b0;
                else rd_cnt <= rd_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clkwiz_clk_in1 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) q_mem[i] <= '0;
            q_head   <= '0;
            q_count  <= '0;
            draining <= 1'b0;
        end else begin
            if (q_push) q_mem[q_tail] <= offset_lo;
            if (q_issue) q_head <= q_head + 2'd1;
            case ({q_push, q_issue})
                2'b10:   q_count <= q_count + 3'd1;
                2'b01:   q_count <= q_count - 3'd1;
                default: ;
            endcase
            if (w_fire && aw_addr == 32'h3c) draining <= 1'b1;
            else if (draining && q_count == 3'd0) draining <= 1'b0;
        end
    end

    // Socket models; STATUS bits are sticky and only cleared through the control block
    always_ff @(posedge clkwiz_clk_in1 or negedge resetn) begin
        if (!resetn) begin
            sock_busy <= '0;
            sock_done <= '0;
            status    <= '0;
            for (int i = 0; i < NUM_SOCKETS; i++) begin
                sock_cnt[i] <= '0;
                ext_lo[i]   <= '0;
                ext_hi[i]   <= '0;
            end
        end else begin
            if (w_fire && aw_addr == 32'h40) status <= '0;
            for (int i = 0; i < NUM_SOCKETS; i++) begin
                if (sock_busy[i]) begin
                    if (sock_cnt[i] == '0) begin
                        sock_busy[i] <= 1'b0;
                        sock_done[i] <= 1'b1;
                        status[i]    <= 1'b1;
                    end else begin
                        sock_cnt[i] <= sock_cnt[i] - 1'b1;
                    end
                end
                if (wr_complete && tgt_hit(wr_target, i)) begin
                    case (wr_target[14:6])
                        9'd64: if (wr_value[0]) begin
                            sock_busy[i] <= 1'b1;
                            sock_done[i] <= 1'b0;
                            sock_cnt[i]  <= RUN_W'(SOCKET_RUN_CYCLES - 1);
                        end
                        9'd65: ext_lo[i] <= wr_value;
                        9'd66: ext_hi[i] <= wr_value;
                        9'd256: if (wr_value[0]) begin
                            sock_busy[i] <= 1'b0;
                            sock_done[i] <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clkwiz_clk_in1 or negedge resetn) begin
        if (!resetn) begin
            gw_run     <= 1'b0;
            gw_cnt     <= '0;
            done_write <= 1'b0;
            gr_run     <= 1'b0;
            gr_cnt     <= '0;
            done_read  <= 1'b0;
            ddr_addr_q <= '0;
            ram_addr_q <= '0;
        end else begin
            if (start_write || start_read) begin
                ddr_addr_q <= ddr_addr;
                ram_addr_q <= ram_addr;
            end
            if (start_write) begin
                gw_run     <= 1'b1;
                gw_cnt     <= gen_len;
                done_write <= 1'b0;
            end else if (gw_run) begin
                if (gw_cnt == '0) begin
                    gw_run     <= 1'b0;
                    done_write <= 1'b1;
                end else begin
                    gw_cnt <= gw_cnt - 33'd1;
                end
            end
            if (start_read) begin
                gr_run    <= 1'b1;
                gr_cnt    <= gen_len;
                done_read <= 1'b0;
            end else if (gr_run) begin
                if (gr_cnt == '0) begin
                    gr_run    <= 1'b0;
                    done_read <= 1'b1;
                end else begin
                    gr_cnt <= gr_cnt - 33'd1;
                end
            end
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_count;

    always_ff @(posedge clkwiz_clk_in1 or negedge resetn) begin
        if (!resetn) cycle_count <= '0;
        else cycle_count <= cycle_count + 32'd1;
    end

    assign cycle_rd = cycle_count;
`else
    assign cycle_rd = 32'd0;
`endif

endmodule

// File: tb/tb_design_1_wrapper_sim_wrapper_top.sv
// Self-checking bench for design_1_wrapper_sim_wrapper_top: randomized control-register,
// socket and generator traffic compared against a behavioural model of the platform.
module tb_design_1_wrapper_sim_wrapper_top;

    logic clk = 1'b0;
    logic resetn;
    logic user_clk;
    logic [31:0] mem_len;
    logic [63:0] ddr_addr, ram_addr;
    logic start_write, start_read, done_write, done_read;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic arvalid, arready, awvalid, awready, wvalid, wready, bvalid, bready, rvalid, rready;
    logic [1:0] bresp, rresp;
    logic unused_act_n, unused_ck_c, unused_ck_t, unused_cke, unused_cs_n, unused_odt, unused_rst_n;
    logic [16:0] unused_adr;
    logic [1:0] unused_ba, unused_bg;
    wire [7:0] unused_dm_n, unused_dqs_c, unused_dqs_t;
    wire [63:0] unused_dq;

    int total = 0;
    int bad = 0;
    logic [31:0] ext_model [4][2];

    always #5 clk = ~clk;

    design_1_wrapper_sim_wrapper_top dut (
        .clkwiz_clk_in1(clk), .resetn(resetn), .user_clk(user_clk),
        .sys_clk_clk_p(1'b0), .sys_clk_clk_n(1'b1), .clkwiz_reset(1'b0),
        .clkwiz_clk_out1_ce(1'b1), .clkwiz_clk_out1_clr_n(1'b1),
        .CH0_DDR4_act_n(unused_act_n), .CH0_DDR4_adr(unused_adr), .CH0_DDR4_ba(unused_ba),
        .CH0_DDR4_bg(unused_bg), .CH0_DDR4_ck_c(unused_ck_c), .CH0_DDR4_ck_t(unused_ck_t),
        .CH0_DDR4_cke(unused_cke), .CH0_DDR4_cs_n(unused_cs_n), .CH0_DDR4_odt(unused_odt),
        .CH0_DDR4_reset_n(unused_rst_n), .CH0_DDR4_dm_n(unused_dm_n),
        .CH0_DDR4_dqs_c(unused_dqs_c), .CH0_DDR4_dqs_t(unused_dqs_t), .CH0_DDR4_dq(unused_dq),
        .mem_len(mem_len), .ddr_addr(ddr_addr), .ram_addr(ram_addr),
        .start_write(start_write), .start_read(start_read),
        .done_write(done_write), .done_read(done_read), .dump_mem(1'b0),
        .s_axi_control_araddr(araddr), .s_axi_control_arvalid(arvalid),
        .s_axi_control_arready(arready), .s_axi_control_awaddr(awaddr),
        .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
        .s_axi_control_wdata(wdata), .s_axi_control_wstrb(4'hf),
        .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
        .s_axi_control_bresp(bresp), .s_axi_control_bvalid(bvalid),
        .s_axi_control_bready(bready), .s_axi_control_rdata(rdata),
        .s_axi_control_rresp(rresp), .s_axi_control_rvalid(rvalid),
        .s_axi_control_rready(rready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // All bus tasks start and end on a falling edge
    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data);
        int n;
        awaddr = addr; awvalid = 1'b1; n = 0;
        while (!awready && n < 32) begin @(negedge clk); n++; end
        checkOutput("awready", awready, 1);
        @(negedge clk); awvalid = 1'b0; wdata = data; wvalid = 1'b1; n = 0;
        while (!wready && n < 32) begin @(negedge clk); n++; end
        checkOutput("wready", wready, 1);
        @(negedge clk); wvalid = 1'b0; bready = 1'b1; n = 0;
        while (!bvalid && n < 32) begin @(negedge clk); n++; end
        checkOutput("bvalid", {bvalid, bresp}, 3'b100);
        @(negedge clk); bready = 1'b0;
    endtask

    task automatic axiRead(input logic [31:0] addr, output logic [31:0] data);
        int n;
        araddr = addr; arvalid = 1'b1; n = 0;
        while (!arready && n < 32) begin @(negedge clk); n++; end
        checkOutput("arready", arready, 1);
        @(negedge clk); arvalid = 1'b0; rready = 1'b1; n = 0;
        while (!rvalid && n < 32) begin @(negedge clk); n++; end
        checkOutput("rvalid", {rvalid, rresp}, 3'b100);
        data = rdata;
        @(negedge clk); rready = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axiRead(addr, d);
        checkOutput(tag, d, exp);
    endtask

    function automatic logic [31:0] sockOffset(input int sock, input int space, input int regn);
        return (32'(sock) << 24) | (32'(space) << 15) | (32'(regn) << 6);
    endfunction

    function automatic logic [31:0] modelRead(input int sock, input int space, input int regn);
        if (space == 1 && sock < 2 && (regn == 65 || regn == 66)) return ext_model[sock][regn-65];
        return 32'd0;
    endfunction

    task automatic socketWrite(input logic [31:0] target, input logic [31:0] value);
        axiWrite(32'h10, target);
        axiWrite(32'h20, value);
        axiWrite(32'h00, 32'd1);
        idle(8);
    endtask

    task automatic socketRead(input string tag, input logic [31:0] target, input logic [31:0] exp);
        axiWrite(32'h24, 32'd0);
        axiWrite(32'h10, target);
        readCheck("csr_read_zero", 32'h00, 32'd0);
        idle(8);
        readCheck("rcnt_set", 32'h24, 32'd1);
        readCheck(tag, 32'h1c, exp);
    endtask

    // Generator latency counted in edges from the start pulse to the first edge showing done
    task automatic genCheck(input bit is_read, input int len);
        int n;
        int exp_lat;
        exp_lat = ((len == 0) ? 1 : len) + 8;
        mem_len = 32'(len);
        ddr_addr = {$urandom, $urandom};
        if (is_read) start_read = 1'b1; else start_write = 1'b1;
        @(posedge clk); #1;
        start_read = 1'b0; start_write = 1'b0;
        checkOutput(is_read ? "gen_rd_clear" : "gen_wr_clear", is_read ? done_read : done_write, 0);
        n = 0;
        while (n < 300) begin
            @(posedge clk); #1; n++;
            if (is_read ? done_read : done_write) break;
        end
        checkOutput(is_read ? "gen_rd_latency" : "gen_wr_latency", 64'(n), 64'(exp_lat));
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int iter);
        int sock, space, regn;
        logic [31:0] val;
        sock = $urandom_range(0, 3); space = ($urandom_range(0, 3) != 0) ? 1 : 0;
        regn = 65 + $urandom_range(0, 1); val = $urandom;
        axiWrite(32'h14, $urandom);
        socketWrite(sockOffset(sock, space, regn), val);
        if (space == 1 && sock < 2) ext_model[sock][regn-65] = val;
        sock = $urandom_range(0, 3); space = ($urandom_range(0, 3) != 0) ? 1 : 0;
        regn = 65 + $urandom_range(0, 1);
        socketRead($sformatf("sock_rd_%0d", iter), sockOffset(sock, space, regn),
                   modelRead(sock, space, regn));
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d, w0, c0;
        logic [31:0] addrs [6];
        logic [31:0] rw_model [3];
        for (int s = 0; s < 4; s++) begin ext_model[s][0] = '0; ext_model[s][1] = '0; end
        resetn = 1'b0; mem_len = '0; ddr_addr = '0; ram_addr = '0;
        start_write = 1'b0; start_read = 1'b0;
        araddr = '0; awaddr = '0; wdata = '0;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;

        // Reset state
        idle(3);
        checkOutput("rst_awready", awready, 0);
        checkOutput("rst_arready", arready, 0);
        checkOutput("rst_done", {done_write, done_read}, 0);
        checkOutput("rst_rdata", rdata, 0);
        @(posedge clk); #1;
        checkOutput("user_clk_high", user_clk, 1);
        @(negedge clk); #1;
        checkOutput("user_clk_low", user_clk, 0);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", {awready, arready, wready, bvalid, rvalid}, 5'b11000);
        readCheck("status_reset", 32'h40, 32'd0);

        // Generator latency, including the zero-length corner
        genCheck(0, 0);
        genCheck(1, 0);
        for (int i = 0; i < 3; i++) begin
            genCheck(0, $urandom_range(1, 40));
            genCheck(1, $urandom_range(1, 40));
        end

        // Plain register file and unmapped addresses
        addrs = '{32'h10, 32'h14, 32'h20, 32'h30, 32'h48, 32'h2c};
        rw_model = '{32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            int k;
            k = $urandom_range(0, 5);
            d = $urandom;
            axiWrite(addrs[k], d);
            if (k < 3) rw_model[k] = d;
            readCheck($sformatf("reg_%0h", addrs[k]), addrs[k], (k < 3) ? rw_model[k] : 32'd0);
        end

        // Single socket write then read back through RDATA
        axiWrite(32'h24, 32'd0);
        axiWrite(32'h10, sockOffset(0, 1, 65));
        axiWrite(32'h20, 32'h5);
        axiWrite(32'h00, 32'd1);
        readCheck("wr_idle_busy", 32'h18, 32'd1);
        idle(8);
        readCheck("wr_idle_done", 32'h18, 32'd0);
        ext_model[0][0] = 32'h5;
        readCheck("csr_read_zero", 32'h00, 32'd0);
        idle(8);
        readCheck("rcnt_one", 32'h24, 32'd1);
        readCheck("rdata_five", 32'h1c, 32'h5);

        for (int i = 0; i < 12; i++) applyStimulus(i);

        // Queue drains two socket starts; STATUS follows after the run time
        axiWrite(32'h40, 32'd0);
        axiRead(32'h28, w0);
        for (int i = 0; i < 2; i++) begin
            axiWrite(32'h10, sockOffset(i, 1, 64));
            axiWrite(32'h38, 32'd0);
        end
        axiWrite(32'h20, 32'd1);
        axiWrite(32'h3c, 32'd0);
        idle(20);
        readCheck("status_running", 32'h40, 32'd0);
        socketRead("sock0_busy", sockOffset(0, 1, 64), 32'd1);
        idle(80);
        readCheck("status_done", 32'h40, 32'd3);
        readCheck("wcnt_queue", 32'h28, w0 + 32'd2);
        socketRead("sock0_done", sockOffset(0, 1, 64), 32'd2);

        // Socket reset and STATUS clear
        socketWrite(sockOffset(0, 1, 256), 32'd1);
        readCheck("status_sticky", 32'h40, 32'd3);
        axiWrite(32'h40, 32'd0);
        readCheck("status_cleared", 32'h40, 32'd0);
        socketRead("sock0_after_reset", sockOffset(0, 1, 64), 32'd0);
        socketRead("sock1_still_done", sockOffset(1, 1, 64), 32'd2);

        // Overfilled queue: only four entries survive
        axiRead(32'h28, w0);
        axiWrite(32'h10, sockOffset(0, 1, 65));
        for (int i = 0; i < 6; i++) axiWrite(32'h38, 32'd0);
        axiWrite(32'h20, 32'h7);
        axiWrite(32'h3c, 32'd0);
        idle(40);
        readCheck("wcnt_queue_full", 32'h28, w0 + 32'd4);
        ext_model[0][0] = 32'h7;
        socketRead("queue_ext_lo", sockOffset(0, 1, 65), modelRead(0, 1, 65));

`ifdef CYCLE_COUNTER_EN
        axiRead(32'h44, c0);
        idle(5);
        axiRead(32'h44, d);
        checkOutput("cycle_advance", 64'(d > c0), 1);
`else
        axiRead(32'h44, c0);
        checkOutput("cycle_disabled", c0, 0);
`endif

        // Reset asserted mid-transaction with a read response still held
        genCheck(0, 3);
        axiWrite(32'h10, 32'hA5A5_0001);
        araddr = 32'h10; arvalid = 1'b1;
        @(negedge clk); arvalid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_rvalid", rvalid, 1);
        checkOutput("pre_rst_rdata", rdata, 32'hA5A5_0001);
        #2 resetn = 1'b0;
        #1;
        checkOutput("midrst_flags", {awready, wready, bvalid, arready, rvalid, done_write, done_read}, 0);
        checkOutput("midrst_rdata", rdata, 0);
        idle(3);
        checkOutput("midrst_hold", {awready, arready, rvalid, done_write, done_read}, 0);
        @(posedge clk); #1;
        checkOutput("midrst_user_clk", user_clk, 1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin ext_model[s][0] = '0; ext_model[s][1] = '0; end
        readCheck("after_rst_offset", 32'h10, 32'd0);
        readCheck("after_rst_status", 32'h40, 32'd0);
        readCheck("after_rst_wcnt", 32'h28, 32'd0);
        socketRead("after_rst_ext", sockOffset(1, 1, 66), modelRead(1, 1, 66));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
